// File: rtl/lsq_load_buffered.sv
// -----------------------------------------------------------------------------
// lsq_load_buffered
//
// Buffered load port between a dataflow circuit and the LSQ interface.
// A one-entry address register decouples the circuit from the interface, a
// counter caps in-flight loads at DEPTH, and a DEPTH-entry FIFO absorbs
// returned data. Because no more than DEPTH loads can be in flight, the FIFO
// always has room for returned data, so the memory side never sees
// back-pressure caused by a stalled consumer.
//
// Parameters
//   DATA_TYPE  load data width in bits
//   ADDR_TYPE  load address width in bits
//   DEPTH      max outstanding loads and data FIFO entries
//
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   addrIn / _valid / _ready          address from the circuit
//   addrOut / _valid / _ready         address to the LSQ interface
//   dataFromMem / _valid / _ready     load data from the LSQ interface
//   dataOut / _valid / _ready         load data to the circuit
//   outstanding                       loads issued whose data has not left
//   idle                              nothing in flight, address register empty
// -----------------------------------------------------------------------------
module lsq_load_buffered #(
  parameter int DATA_TYPE = 32,
  parameter int ADDR_TYPE = 32,
  parameter int DEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         rst,

  input  logic [ADDR_TYPE-1:0]         addrIn,
  input  logic                         addrIn_valid,
  output logic                         addrIn_ready,

  output logic [ADDR_TYPE-1:0]         addrOut,
  output logic                         addrOut_valid,
  input  logic                         addrOut_ready,

  input  logic [DATA_TYPE-1:0]         dataFromMem,
  input  logic                         dataFromMem_valid,
  output logic                         dataFromMem_ready,

  output logic [DATA_TYPE-1:0]         dataOut,
  output logic                         dataOut_valid,
  input  logic                         dataOut_ready,

  output logic [$clog2(DEPTH+1)-1:0]   outstanding,
  output logic                         idle
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  // Circular pointer advance; explicit wrap so non-power-of-two DEPTH works.
  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_LAST) begin
      return '0;
    end
    return ptr + PTR_ONE;
  endfunction

  // Up/down counter step; both directions in one cycle cancel.
  function automatic logic [CNT_W-1:0] stepCount(input logic [CNT_W-1:0] cnt,
                                                 input logic             inc,
                                                 input logic             dec);
    logic [CNT_W-1:0] res;
    res = cnt;
    if (inc && !dec) begin
      res = cnt + CNT_ONE;
    end else if (dec && !inc) begin
      res = cnt - CNT_ONE;
    end
    return res;
  endfunction

  // Address register state (vld_p1 is the address-register full flag).
  logic [ADDR_TYPE-1:0] addrData_p1;
  logic                 vld_p1;

  // In-flight load counter.
  logic [CNT_W-1:0]     outCnt;

  // Data FIFO state.
  logic [DATA_TYPE-1:0] fifoMem [DEPTH];
  logic [PTR_W-1:0]     rdPtr;
  logic [PTR_W-1:0]     wrPtr;
  logic [CNT_W-1:0]     fifoCount;
  logic                 fifoFull;
  logic                 fifoEmpty;

  // Handshake strobes.
  logic addrInFire;
  logic addrOutFire;
  logic pushFire;
  logic popFire;

  // Next-state values.
  logic                 vldNext;
  logic [CNT_W-1:0]     outCntNext;
  logic [CNT_W-1:0]     fifoCountNext;
  logic [PTR_W-1:0]     rdPtrNext;
  logic [PTR_W-1:0]     wrPtrNext;

  assign fifoFull  = (fifoCount == DEPTH_CNT);
  assign fifoEmpty = (fifoCount == '0);

  // Issue is held back while DEPTH loads are already in flight; the valid
  // depends only on registered state, never on addrOut_ready.
  assign addrOut       = addrData_p1;
  assign addrOut_valid = vld_p1 && (outCnt < DEPTH_CNT);

  // Ready looks through to the downstream handshake so a full register can
  // be refilled in the same cycle it issues.
  assign addrIn_ready  = !vld_p1 || (addrOut_valid && addrOut_ready);

  // Registered-only ready: no combinational path from dataOut_ready.
  assign dataFromMem_ready = !fifoFull;
  assign dataOut           = fifoMem[rdPtr];
  assign dataOut_valid     = !fifoEmpty;

  assign outstanding = outCnt;
  assign idle        = (outCnt == '0) && !vld_p1;

  assign addrInFire  = addrIn_valid      && addrIn_ready;
  assign addrOutFire = addrOut_valid     && addrOut_ready;
  assign pushFire    = dataFromMem_valid && dataFromMem_ready;
  assign popFire     = dataOut_valid     && dataOut_ready;

  always_comb begin
    vldNext       = vld_p1;
    outCntNext    = stepCount(outCnt, addrOutFire, popFire);
    fifoCountNext = stepCount(fifoCount, pushFire, popFire);
    rdPtrNext     = rdPtr;
    wrPtrNext     = wrPtr;

    // A new address overrides the drain of the old one.
    if (addrInFire) begin
      vldNext = 1'b1;
    end else if (addrOutFire) begin
      vldNext = 1'b0;
    end

    if (pushFire) begin
      wrPtrNext = nextPtr(wrPtr);
    end
    if (popFire) begin
      rdPtrNext = nextPtr(rdPtr);
    end
  end

  // ---- stage p1: control state (reset) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      outCnt    <= '0;
      fifoCount <= '0;
      rdPtr     <= '0;
      wrPtr     <= '0;
    end else begin
      vld_p1    <= vldNext;
      outCnt    <= outCntNext;
      fifoCount <= fifoCountNext;
      rdPtr     <= rdPtrNext;
      wrPtr     <= wrPtrNext;
    end
  end

  // ---- stage p1: datapath storage (no reset, contents don't-care) ----
  always_ff @(posedge clk) begin
    if (addrInFire) begin
      addrData_p1 <= addrIn;
    end
    if (pushFire) begin
      fifoMem[wrPtr] <= dataFromMem;
    end
  end

  // Data can only leave for a load that was issued, and the FIFO can never
  // overflow because its ready is taken from registered state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(popFire && (outCnt == '0)));
      assert (!(pushFire && fifoFull));
      assert (outCnt <= DEPTH_CNT);
    end
  end

endmodule

// File: tb/tb_lsq_load_buffered.sv
module tb_lsq_load_buffered;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DEPTH=4 instance
  logic [31:0] aAddrIn = '0;
  logic        aAddrInValid = 1'b0;
  logic        aAddrInReady;
  logic [31:0] aAddrOut;
  logic        aAddrOutValid;
  logic        aAddrOutReady = 1'b0;
  logic [31:0] aDfm = '0;
  logic        aDfmValid = 1'b0;
  logic        aDfmReady;
  logic [31:0] aDataOut;
  logic        aDataOutValid;
  logic        aDataOutReady = 1'b0;
  logic [2:0]  aOutstanding;
  logic        aIdle;

  // DEPTH=3 instance
  logic [31:0] bAddrIn = '0;
  logic        bAddrInValid = 1'b0;
  logic        bAddrInReady;
  logic [31:0] bAddrOut;
  logic        bAddrOutValid;
  logic        bAddrOutReady = 1'b0;
  logic [31:0] bDfm = '0;
  logic        bDfmValid = 1'b0;
  logic        bDfmReady;
  logic [31:0] bDataOut;
  logic        bDataOutValid;
  logic        bDataOutReady = 1'b0;
  logic [1:0]  bOutstanding;
  logic        bIdle;

  lsq_load_buffered #(.DATA_TYPE(32), .ADDR_TYPE(32), .DEPTH(4)) dutA (
    .clk(clk), .rst(rst),
    .addrIn(aAddrIn), .addrIn_valid(aAddrInValid), .addrIn_ready(aAddrInReady),
    .addrOut(aAddrOut), .addrOut_valid(aAddrOutValid), .addrOut_ready(aAddrOutReady),
    .dataFromMem(aDfm), .dataFromMem_valid(aDfmValid), .dataFromMem_ready(aDfmReady),
    .dataOut(aDataOut), .dataOut_valid(aDataOutValid), .dataOut_ready(aDataOutReady),
    .outstanding(aOutstanding), .idle(aIdle)
  );

  lsq_load_buffered #(.DATA_TYPE(32), .ADDR_TYPE(32), .DEPTH(3)) dutB (
    .clk(clk), .rst(rst),
    .addrIn(bAddrIn), .addrIn_valid(bAddrInValid), .addrIn_ready(bAddrInReady),
    .addrOut(bAddrOut), .addrOut_valid(bAddrOutValid), .addrOut_ready(bAddrOutReady),
    .dataFromMem(bDfm), .dataFromMem_valid(bDfmValid), .dataFromMem_ready(bDfmReady),
    .dataOut(bDataOut), .dataOut_valid(bDataOutValid), .dataOut_ready(bDataOutReady),
    .outstanding(bOutstanding), .idle(bIdle)
  );

  typedef struct {
    logic [31:0] d;
    int          due;
  } ret_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] wrapWord(input int k);
    return 32'hC0DE_0000 + k;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++; if (aAddrOutValid !== 1'b0) begin errors++; $display("FAIL reset_addrOut_valid got=%0b exp=0", aAddrOutValid); end
    checks++; if (aDataOutValid !== 1'b0) begin errors++; $display("FAIL reset_dataOut_valid got=%0b exp=0", aDataOutValid); end
    checks++; if (aOutstanding !== 3'd0) begin errors++; $display("FAIL reset_outstanding got=%0d exp=0", aOutstanding); end
    checks++; if (aIdle !== 1'b1) begin errors++; $display("FAIL reset_idle got=%0b exp=1", aIdle); end
    checks++; if (aAddrInReady !== 1'b1) begin errors++; $display("FAIL reset_addrIn_ready got=%0b exp=1", aAddrInReady); end
    checks++; if (aDfmReady !== 1'b1) begin errors++; $display("FAIL reset_dataFromMem_ready got=%0b exp=1", aDfmReady); end
    checks++; if (bIdle !== 1'b1) begin errors++; $display("FAIL reset_b_idle got=%0b exp=1", bIdle); end
    checks++; if (bDfmReady !== 1'b1) begin errors++; $display("FAIL reset_b_dataFromMem_ready got=%0b exp=1", bDfmReady); end
  endtask

  task automatic test_single();
    aAddrOutReady = 1'b1;
    aAddrIn = 32'h10;
    aAddrInValid = 1'b1;
    #1;
    checks++; if (aAddrInReady !== 1'b1) begin errors++; $display("FAIL single_addrIn_ready got=%0b exp=1", aAddrInReady); end
    tick();
    aAddrInValid = 1'b0;
    #1;
    checks++; if (aAddrOut !== 32'h10) begin errors++; $display("FAIL single_addrOut got=%0h exp=10", aAddrOut); end
    checks++; if (aAddrOutValid !== 1'b1) begin errors++; $display("FAIL single_addrOut_valid got=%0b exp=1", aAddrOutValid); end
    checks++; if (aOutstanding !== 3'd0) begin errors++; $display("FAIL single_outstanding_pre got=%0d exp=0", aOutstanding); end
    tick();
    checks++; if (aOutstanding !== 3'd1) begin errors++; $display("FAIL single_outstanding_post got=%0d exp=1", aOutstanding); end
    checks++; if (aAddrOutValid !== 1'b0) begin errors++; $display("FAIL single_addrOut_valid_drop got=%0b exp=0", aAddrOutValid); end
    checks++; if (aIdle !== 1'b0) begin errors++; $display("FAIL single_idle_busy got=%0b exp=0", aIdle); end
    aDfm = 32'h55;
    aDfmValid = 1'b1;
    aDataOutReady = 1'b0;
    #1;
    checks++; if (aDataOutValid !== 1'b0) begin errors++; $display("FAIL single_no_bypass got=%0b exp=0", aDataOutValid); end
    tick();
    aDfmValid = 1'b0;
    #1;
    checks++; if (aDataOutValid !== 1'b1) begin errors++; $display("FAIL single_dataOut_valid got=%0b exp=1", aDataOutValid); end
    checks++; if (aDataOut !== 32'h55) begin errors++; $display("FAIL single_dataOut got=%0h exp=55", aDataOut); end
    aDataOutReady = 1'b1;
    tick();
    aDataOutReady = 1'b0;
    #1;
    checks++; if (aOutstanding !== 3'd0) begin errors++; $display("FAIL single_outstanding_done got=%0d exp=0", aOutstanding); end
    checks++; if (aIdle !== 1'b1) begin errors++; $display("FAIL single_idle_done got=%0b exp=1", aIdle); end
  endtask

  task automatic test_back_to_back();
    ret_t retQ[$];
    ret_t ent;
    int sent = 0;
    int issued = 0;
    int rx = 0;
    int firstIss = -1;
    int lastIss = -1;
    aAddrOutReady = 1'b1;
    aDataOutReady = 1'b1;
    for (int cyc = 0; cyc < 40 && rx < 8; cyc++) begin
      aAddrIn = sent;
      aAddrInValid = (sent < 8);
      if (retQ.size() > 0 && retQ[0].due <= cyc) begin
        aDfm = retQ[0].d;
        aDfmValid = 1'b1;
      end else begin
        aDfmValid = 1'b0;
      end
      #1;
      if (aAddrInValid) begin
        checks++;
        if (aAddrInReady !== 1'b1) begin errors++; $display("FAIL stream_addrIn_ready cyc=%0d got=%0b exp=1", cyc, aAddrInReady); end
        else sent++;
      end
      if (aDfmValid && aDfmReady) void'(retQ.pop_front());
      if (aAddrOutValid && aAddrOutReady) begin
        checks++;
        if (aAddrOut !== issued) begin errors++; $display("FAIL stream_addrOut got=%0h exp=%0h", aAddrOut, issued); end
        ent.d = aAddrOut + 32'h100;
        ent.due = cyc + 2;
        retQ.push_back(ent);
        if (firstIss < 0) firstIss = cyc;
        lastIss = cyc;
        issued++;
      end
      if (aDataOutValid && aDataOutReady) begin
        checks++;
        if (aDataOut !== 32'h100 + rx) begin errors++; $display("FAIL stream_dataOut got=%0h exp=%0h", aDataOut, 32'h100 + rx); end
        rx++;
      end
      checks++;
      if (aOutstanding > 3'd4) begin errors++; $display("FAIL stream_outstanding_cap got=%0d exp<=4", aOutstanding); end
      tick();
    end
    aAddrInValid = 1'b0;
    aDfmValid = 1'b0;
    aDataOutReady = 1'b0;
    #1;
    checks++; if (rx !== 8) begin errors++; $display("FAIL stream_rx_count got=%0d exp=8", rx); end
    checks++; if (lastIss - firstIss !== 7) begin errors++; $display("FAIL stream_issue_span got=%0d exp=7", lastIss - firstIss); end
    checks++; if (aOutstanding !== 3'd0) begin errors++; $display("FAIL stream_outstanding_end got=%0d exp=0", aOutstanding); end
    checks++; if (aIdle !== 1'b1) begin errors++; $display("FAIL stream_idle_end got=%0b exp=1", aIdle); end
  endtask

  task automatic test_cap();
    aAddrOutReady = 1'b1;
    aDataOutReady = 1'b0;
    for (int k = 0; k < 5; k++) begin
      aAddrIn = 32'h20 + k;
      aAddrInValid = 1'b1;
      #1;
      checks++; if (aAddrInReady !== 1'b1) begin errors++; $display("FAIL cap_addrIn_ready k=%0d got=%0b exp=1", k, aAddrInReady); end
      tick();
    end
    aAddrIn = 32'h25;
    #1;
    checks++; if (aOutstanding !== 3'd4) begin errors++; $display("FAIL cap_outstanding got=%0d exp=4", aOutstanding); end
    checks++; if (aAddrOutValid !== 1'b0) begin errors++; $display("FAIL cap_addrOut_valid got=%0b exp=0", aAddrOutValid); end
    checks++; if (aAddrOut !== 32'h24) begin errors++; $display("FAIL cap_addrOut_held got=%0h exp=24", aAddrOut); end
    checks++; if (aAddrInReady !== 1'b0) begin errors++; $display("FAIL cap_addrIn_stall got=%0b exp=0", aAddrInReady); end
    tick();
    aDfm = 32'hEE;
    aDfmValid = 1'b1;
    #1;
    checks++; if (aAddrInReady !== 1'b0) begin errors++; $display("FAIL cap_addrIn_stall2 got=%0b exp=0", aAddrInReady); end
    tick();
    aDfmValid = 1'b0;
    aDataOutReady = 1'b1;
    #1;
    checks++; if (aDataOut !== 32'hEE) begin errors++; $display("FAIL cap_dataOut got=%0h exp=ee", aDataOut); end
    checks++; if (aAddrOutValid !== 1'b0) begin errors++; $display("FAIL cap_still_blocked got=%0b exp=0", aAddrOutValid); end
    tick();
    aDataOutReady = 1'b0;
    aAddrInValid = 1'b0;
    #1;
    checks++; if (aAddrOutValid !== 1'b1) begin errors++; $display("FAIL cap_release_valid got=%0b exp=1", aAddrOutValid); end
    checks++; if (aAddrOut !== 32'h24) begin errors++; $display("FAIL cap_release_addr got=%0h exp=24", aAddrOut); end
    checks++; if (aOutstanding !== 3'd3) begin errors++; $display("FAIL cap_release_outstanding got=%0d exp=3", aOutstanding); end
    tick();
    checks++; if (aOutstanding !== 3'd4) begin errors++; $display("FAIL cap_refill_outstanding got=%0d exp=4", aOutstanding); end
    checks++; if (aIdle !== 1'b0) begin errors++; $display("FAIL cap_idle got=%0b exp=0", aIdle); end
  endtask

  task automatic test_fifo_full();
    aDataOutReady = 1'b0;
    for (int k = 0; k < 4; k++) begin
      aDfm = 32'hA + k;
      aDfmValid = 1'b1;
      #1;
      checks++; if (aDfmReady !== 1'b1) begin errors++; $display("FAIL full_ready k=%0d got=%0b exp=1", k, aDfmReady); end
      tick();
    end
    aDfmValid = 1'b0;
    #1;
    checks++; if (aDfmReady !== 1'b0) begin errors++; $display("FAIL full_ready_drop got=%0b exp=0", aDfmReady); end
    checks++; if (aDataOut !== 32'hA) begin errors++; $display("FAIL full_head got=%0h exp=a", aDataOut); end
    checks++; if (aOutstanding !== 3'd4) begin errors++; $display("FAIL full_outstanding got=%0d exp=4", aOutstanding); end
    for (int k = 0; k < 4; k++) begin
      aDataOutReady = 1'b1;
      #1;
      checks++; if (aDataOutValid !== 1'b1) begin errors++; $display("FAIL drain_valid k=%0d got=%0b exp=1", k, aDataOutValid); end
      checks++; if (aDataOut !== 32'hA + k) begin errors++; $display("FAIL drain_data got=%0h exp=%0h", aDataOut, 32'hA + k); end
      tick();
    end
    aDataOutReady = 1'b0;
    #1;
    checks++; if (aOutstanding !== 3'd0) begin errors++; $display("FAIL drain_outstanding got=%0d exp=0", aOutstanding); end
    checks++; if (aIdle !== 1'b1) begin errors++; $display("FAIL drain_idle got=%0b exp=1", aIdle); end
    checks++; if (aDataOutValid !== 1'b0) begin errors++; $display("FAIL drain_empty got=%0b exp=0", aDataOutValid); end
    checks++; if (aDfmReady !== 1'b1) begin errors++; $display("FAIL drain_ready got=%0b exp=1", aDfmReady); end
  endtask

  task automatic test_wrap();
    bAddrOutReady = 1'b1;
    bAddrIn = 32'h40;
    bAddrInValid = 1'b1;
    bDataOutReady = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    checks++; if (bOutstanding !== 2'd3) begin errors++; $display("FAIL wrap_outstanding got=%0d exp=3", bOutstanding); end
    checks++; if (bAddrOutValid !== 1'b0) begin errors++; $display("FAIL wrap_capped got=%0b exp=0", bAddrOutValid); end
    for (int k = 0; k < 2; k++) begin
      bDfm = wrapWord(k);
      bDfmValid = 1'b1;
      #1;
      checks++; if (bDfmReady !== 1'b1) begin errors++; $display("FAIL wrap_fill_ready k=%0d got=%0b exp=1", k, bDfmReady); end
      tick();
    end
    for (int k = 0; k < 7; k++) begin
      bDfm = wrapWord(k + 2);
      bDfmValid = 1'b1;
      bDataOutReady = 1'b1;
      #1;
      checks++; if (bDataOutValid !== 1'b1 || bDataOut !== wrapWord(k)) begin errors++; $display("FAIL wrap_stream_data got=%0h exp=%0h", bDataOut, wrapWord(k)); end
      checks++; if (bDfmReady !== 1'b1) begin errors++; $display("FAIL wrap_stream_ready k=%0d got=%0b exp=1", k, bDfmReady); end
      tick();
    end
    bDfm = wrapWord(9);
    bDfmValid = 1'b1;
    bDataOutReady = 1'b0;
    #1;
    checks++; if (bDfmReady !== 1'b1) begin errors++; $display("FAIL wrap_count2_ready got=%0b exp=1", bDfmReady); end
    tick();
    bDfmValid = 1'b0;
    #1;
    checks++; if (bDfmReady !== 1'b0) begin errors++; $display("FAIL wrap_count3_full got=%0b exp=0", bDfmReady); end
    for (int k = 7; k < 10; k++) begin
      bDataOutReady = 1'b1;
      #1;
      checks++; if (bDataOutValid !== 1'b1 || bDataOut !== wrapWord(k)) begin errors++; $display("FAIL wrap_drain_data got=%0h exp=%0h", bDataOut, wrapWord(k)); end
      tick();
    end
    bDataOutReady = 1'b0;
    bAddrInValid = 1'b0;
    #1;
    checks++; if (bDataOutValid !== 1'b0) begin errors++; $display("FAIL wrap_empty got=%0b exp=0", bDataOutValid); end
  endtask

  task automatic test_midop_reset();
    aAddrOutReady = 1'b1;
    aDataOutReady = 1'b0;
    for (int k = 0; k < 4; k++) begin
      aAddrIn = 32'h30 + k;
      aAddrInValid = (k < 3);
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      aDfm = 32'h77 + k;
      aDfmValid = 1'b1;
      tick();
    end
    aDfmValid = 1'b0;
    aAddrOutReady = 1'b0;
    aAddrIn = 32'h33;
    aAddrInValid = 1'b1;
    tick();
    aAddrInValid = 1'b0;
    #1;
    checks++; if (aOutstanding !== 3'd3) begin errors++; $display("FAIL midop_outstanding_pre got=%0d exp=3", aOutstanding); end
    checks++; if (aDataOutValid !== 1'b1 || aDataOut !== 32'h77) begin errors++; $display("FAIL midop_head_pre got=%0h exp=77", aDataOut); end
    checks++; if (aAddrOutValid !== 1'b1) begin errors++; $display("FAIL midop_addr_pending got=%0b exp=1", aAddrOutValid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (aOutstanding !== 3'd0) begin errors++; $display("FAIL midop_outstanding got=%0d exp=0", aOutstanding); end
    checks++; if (aDataOutValid !== 1'b0) begin errors++; $display("FAIL midop_dataOut_valid got=%0b exp=0", aDataOutValid); end
    checks++; if (aAddrOutValid !== 1'b0) begin errors++; $display("FAIL midop_addrOut_valid got=%0b exp=0", aAddrOutValid); end
    checks++; if (aIdle !== 1'b1) begin errors++; $display("FAIL midop_idle got=%0b exp=1", aIdle); end
    checks++; if (aAddrInReady !== 1'b1) begin errors++; $display("FAIL midop_addrIn_ready got=%0b exp=1", aAddrInReady); end
    checks++; if (aDfmReady !== 1'b1) begin errors++; $display("FAIL midop_dataFromMem_ready got=%0b exp=1", aDfmReady); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_cap();
    test_fifo_full();
    test_wrap();
    test_midop_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsq_load_buffered.md
Name: lsq_load_buffered

Overview:
- Load port between a dataflow circuit and the LSQ interface. It is the buffered successor of the zero-latency pass-through load port.
- Registers the address channel and caps in-flight loads at DEPTH.
- Queues returned data in a DEPTH-entry FIFO, so the memory side is never back-pressured by a stalled consumer.
- Exposes the in-flight count for debug and for quiescence detection.

Parameters:
DATA_TYPE, 32, data width in bits (>=1)
ADDR_TYPE, 32, address width in bits (>=1)
DEPTH, 4, max outstanding loads and data FIFO entries (>=1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
addrIn  in  ADDR_TYPE  load address from circuit
addrIn_valid  in  1  address valid
addrIn_ready  out  1  address accepted
addrOut  out  ADDR_TYPE  address to LSQ interface
addrOut_valid  out  1  address to interface valid
addrOut_ready  in  1  interface accepts address
dataFromMem  in  DATA_TYPE  load data from interface
dataFromMem_valid  in  1  load data valid
dataFromMem_ready  out  1  port accepts load data
dataOut  out  DATA_TYPE  load data to circuit
dataOut_valid  out  1  load data valid
dataOut_ready  in  1  circuit accepts data
outstanding  out  $clog2(DEPTH+1)  loads issued whose data has not yet left on dataOut
idle  out  1  outstanding==0 and address register empty

Behaviour:
- Handshake fires when valid&&ready on the rising edge. Valid must not depend combinationally on ready of the same channel.
- Address register (1 entry, addr_full flag):
  - addrOut = stored address.
  - addrOut_valid = addr_full && (outstanding < DEPTH).
  - addrIn_ready = !addr_full || (addrOut_valid && addrOut_ready), i.e. full throughput with a combinational ready path.
  - Latency addrIn to addrOut_valid: 1 cycle.
  - Accept and issue in the same cycle: register reloads with the new address, addr_full stays 1.
- Outstanding counter:
  - +1 on an addrOut handshake; -1 on a dataOut handshake; both in the same cycle leaves it unchanged.
  - When outstanding==DEPTH, addrOut_valid is forced 0; the address is held and addrIn stalls once the register is full.
  - Never exceeds DEPTH and never underflows. A dataOut handshake at outstanding==0 is impossible by construction; assert on it in simulation.
- Data FIFO (DEPTH entries, circular read/write pointers plus count):
  - dataFromMem_ready = !fifo_full (registered state only).
  - Push on a dataFromMem handshake; pop on a dataOut handshake.
  - dataOut = head entry; dataOut_valid = !fifo_empty.
  - Latency dataFromMem handshake to dataOut_valid: 1 cycle. No bypass.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Pointers wrap DEPTH-1 to 0 (non-power-of-two DEPTH supported).
  - Full and push attempted: impossible because ready=0. Empty and pop attempted: impossible because valid=0.
  - Order is preserved; the interface returns data in address order.
- Because outstanding <= DEPTH, returned data always fits. fifo_full implies outstanding==DEPTH.
- idle = (outstanding==0) && !addr_full.
- Reset (synchronous, active-high): clears addr_full, FIFO pointers and count, and the counter. The first cycle after reset has:
  - addrOut_valid=0, dataOut_valid=0, outstanding=0, idle=1;
  - addrIn_ready=1, dataFromMem_ready=1.
- Reset asserted mid-operation discards all in-flight addresses and data; the outputs above hold on the following edge. Stored data and address contents are don't-care after reset.

Test Plan:
- DEPTH=4, reset, then addrIn=0x10 valid one cycle with addrOut_ready=1 -> addrOut=0x10, addrOut_valid=1 next cycle; outstanding=1 after the handshake.
- Stream 8 back-to-back addresses 0x0..0x7 with addrOut_ready=1 and dataOut_ready=1, interface returning data = addr+0x100 two cycles later -> one address per cycle, dataOut sequence 0x100..0x107 in order, outstanding never >4.
- Issue 4 addresses with no data returned -> outstanding=4; the 5th address is held in the register with addrOut_valid=0, and the 6th sees addrIn_ready=0. Return one data and consume it -> the 5th address issues the next cycle.
- dataOut_ready=0, return 4 data words 0xA..0xD -> dataFromMem_ready drops to 0 after the 4th. Raise dataOut_ready -> 0xA,0xB,0xC,0xD on consecutive cycles, then outstanding=0 and idle=1.
- Simultaneous push/pop at count=2 and pointer wrap with DEPTH=3 -> count stays 2; data order correct across wrap for 10 words.
- Assert rst for one cycle with 3 loads outstanding and the FIFO holding 2 words -> next cycle outstanding=0, dataOut_valid=0, addrOut_valid=0, idle=1, addrIn_ready=1.
